lcd_cmd_sequencer: RTL and testbench

Upstream driver for the 12x9 LCD image controller: buffers host commands in a small FIFO and issues them one at a time on the controller's cmd/cmd_valid interface, honouring its busy handshake. On a load command (cmd=0) it streams the 108-byte image from a synchronous image memory onto datain, one byte per cycle. The sequencer sits between the host/testbench command source and the LCD controller, so the host never has to track busy timing.

---
 rtl/lcd_cmd_sequencer_if.sv | 29 ++
 rtl/lcd_cmd_sequencer.sv | 155 +++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_sequencer_if.sv
// lcd_cmd_sequencer_if
//   Bundles the sequencer's host-command, image-memory and LCD-controller
//   signals.
//   master : the sequencer. It drives hcmd_full, img_addr, img_rd, cmd,
//            cmd_valid, datain and seq_idle.
//   slave  : the environment, which is the host, the image memory and the
//            controller. It drives hcmd, hcmd_push, img_data and busy.
interface lcd_cmd_sequencer_if #(parameter int ADDR_W = 7);
  logic [2:0]        hcmd;
  logic              hcmd_push;
  logic              hcmd_full;
  logic [ADDR_W-1:0] img_addr;
  logic              img_rd;
  logic [7:0]        img_data;
  logic              busy;
  logic [2:0]        cmd;
  logic              cmd_valid;
  logic [7:0]        datain;
  logic              seq_idle;

  modport master (
    input  hcmd, hcmd_push, img_data, busy,
    output hcmd_full, img_addr, img_rd, cmd, cmd_valid, datain, seq_idle
  );
  modport slave (
    output hcmd, hcmd_push, img_data, busy,
    input  hcmd_full, img_addr, img_rd, cmd, cmd_valid, datain, seq_idle
  );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
//   Buffers host commands in a FIFO and issues them one at a time to the
//   12x9 LCD image controller, honouring its busy handshake. A load
//   command (code 0) streams IMG_BYTES image bytes from a synchronous
//   image memory onto datain, one byte per cycle. Code 7 is discarded.
// Ports
//   clk, rst : clock; asynchronous active-high reset
//   bus      : lcd_cmd_sequencer_if.master, which carries host push/full,
//              the image memory read port, and controller cmd/cmd_valid/
//              busy/datain plus seq_idle
// Optional feature (macro LCD_SEQ_PERF_EN)
//   cmd_count_o  : saturating count of cmd_valid strobes
//   drop_count_o : saturating count of full-FIFO drops and discarded code 7s
module lcd_cmd_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_BYTES  = 108,
  parameter int ADDR_W     = 7
) (
  input  logic clk,
  input  logic rst,
  lcd_cmd_sequencer_if.master bus
`ifdef LCD_SEQ_PERF_EN
  ,
  output logic [15:0] cmd_count_o,
  output logic [15:0] drop_count_o
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_BYTES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, LOAD, ACK, DONE} state_t;

  state_t            state_q;
  logic [2:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic              full_q;
  logic [2:0]        cmd_q;
  logic              cmd_valid_q;
  logic              img_rd_q;
  logic [ADDR_W-1:0] img_addr_q;
  logic              rd_vld_q;   // img_data holds a valid byte this cycle
  logic [7:0]        dhold_q;    // last byte driven, held outside LOAD
  logic              empty, pop, push_ok;
  logic [2:0]        head;

  // When the FIFO is empty, an incoming push is bypassed straight to the head
  // so that it can be popped in the same cycle. Popping is also allowed from
  // DONE, which puts the next strobe right after busy is seen low.
  always_comb begin
    empty   = (cnt_q == '0);
    head    = empty ? bus.hcmd : fifo_q[rd_ptr_q];
    pop     = (state_q == IDLE || state_q == DONE) && !bus.busy &&
              (!empty || bus.hcmd_push);
    push_ok = bus.hcmd_push && (!full_q || pop);
    cnt_d   = cnt_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
  end

  // The FIFO storage needs no reset because the pointers define its contents.
  always_ff @(posedge clk)
    if (push_ok) fifo_q[wr_ptr_q] <= bus.hcmd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      img_rd_q    <= 1'b0;
      img_addr_q  <= '0;
      rd_vld_q    <= 1'b0;
      dhold_q     <= '0;
    end else begin
      cnt_q       <= cnt_d;
      full_q      <= (cnt_d == (PTR_W+1)'(FIFO_DEPTH));
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cmd_valid_q <= 1'b0;
      rd_vld_q    <= img_rd_q;
      if (rd_vld_q) dhold_q <= bus.img_data;

      case (state_q)
        IDLE, DONE: begin
          if (pop) begin
            if (head == 3'd7) begin
              state_q <= IDLE;
            end else begin
              state_q     <= ISSUE;
              cmd_q       <= head;
              cmd_valid_q <= 1'b1;
              if (head == 3'd0) begin
                img_rd_q   <= 1'b1;
                img_addr_q <= '0;
              end
            end
          end else if (state_q == DONE && !bus.busy) begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          if (cmd_q == 3'd0) begin
            state_q <= LOAD;
            if (img_addr_q == LAST) img_rd_q <= 1'b0;
            else                    img_addr_q <= img_addr_q + ADDR_W'(1);
          end else begin
            state_q <= ACK;
          end
        end
        LOAD: begin
          // The read phase ends at address LAST. One more cycle then carries
          // the final byte before the move to DONE.
          if (img_rd_q) begin
            if (img_addr_q == LAST) img_rd_q <= 1'b0;
            else                    img_addr_q <= img_addr_q + ADDR_W'(1);
          end else begin
            state_q <= DONE;
          end
        end
        ACK:     state_q <= DONE;  // the controller raises busy only now
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.hcmd_full = full_q;
  assign bus.cmd       = cmd_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.img_rd    = img_rd_q;
  assign bus.img_addr  = img_addr_q;
  // The memory returns data one cycle after img_rd. Passing it through
  // combinationally puts byte k on datain at c+1+k.
  assign bus.datain    = rd_vld_q ? bus.img_data : dhold_q;
  assign bus.seq_idle  = (state_q == IDLE) && empty;

`ifdef LCD_SEQ_PERF_EN
  logic [15:0] cmd_count_q, drop_count_q;
  logic        drop_ev;
  assign drop_ev = (bus.hcmd_push && !push_ok) || (pop && head == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (cmd_valid_q && cmd_count_q != 16'hFFFF) cmd_count_q <= cmd_count_q + 16'd1;
      if (drop_ev && drop_count_q != 16'hFFFF)    drop_count_q <= drop_count_q + 16'd1;
    end
  end
  assign cmd_count_o  = cmd_count_q;
  assign drop_count_o = drop_count_q;
`endif
endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
module tb_lcd_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_cmd_sequencer_if #(.ADDR_W(7)) bus();

`ifdef LCD_SEQ_PERF_EN
  logic [15:0] cmd_count, drop_count;
  lcd_cmd_sequencer dut (.clk(clk), .rst(rst), .bus(bus.master),
                         .cmd_count_o(cmd_count), .drop_count_o(drop_count));
`else
  lcd_cmd_sequencer dut (.clk(clk), .rst(rst), .bus(bus.master));
`endif

  // Image memory model: address k holds k+8.
  always @(posedge clk)
    if (bus.img_rd) bus.img_data <= 8'(bus.img_addr) + 8'd8;

  // Controller busy model: busy is high for busy_len cycles after each strobe,
  // or whenever busy_force is set.
  int busy_len   = 0;
  bit busy_force = 1'b0;
  int bcnt       = 0;
  always @(posedge clk or posedge rst)
    if (rst)                bcnt <= 0;
    else if (bus.cmd_valid) bcnt <= busy_len;
    else if (bcnt != 0)     bcnt <= bcnt - 1;
  assign bus.busy = busy_force || (bcnt != 0);

  // Scoreboard queues.
  typedef struct { int cmd; int gap; } exp_t;   // gap 0 = spacing not pinned
  typedef struct { int kind; int val; } stat_t; // 0 full,1 idle,2 pending,3 drop
  exp_t  exp_q[$];
  stat_t stat_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor samples on the falling edge.
  int cyc = 0, last_strobe = -1, ld_c = 0, hold_exp = 0;
  bit ld_act = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      ld_act      = 1'b0;
      hold_exp    = 0;
      last_strobe = -1;
      chk("rst_cmd_valid", int'(bus.cmd_valid), 0);
      chk("rst_img_rd",    int'(bus.img_rd), 0);
      chk("rst_seq_idle",  int'(bus.seq_idle), 1);
      chk("rst_hcmd_full", int'(bus.hcmd_full), 0);
      chk("rst_datain",    int'(bus.datain), 0);
    end else begin
      while (stat_q.size() != 0) begin
        stat_t s;
        s = stat_q.pop_front();
        case (s.kind)
          0: chk("hcmd_full", int'(bus.hcmd_full), s.val);
          1: chk("seq_idle", int'(bus.seq_idle), s.val);
          2: chk("pending_strobes", exp_q.size(), s.val);
`ifdef LCD_SEQ_PERF_EN
          3: chk("drop_count", int'(drop_count), s.val);
`endif
          default: ;
        endcase
      end
      if (bus.cmd_valid) begin
        if (last_strobe >= 0) chk("strobe_gap_ge2", int'(cyc - last_strobe >= 2), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe_cmd", int'(bus.cmd), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("cmd", int'(bus.cmd), e.cmd);
          if (e.gap != 0) chk("strobe_gap", cyc - last_strobe, e.gap);
        end
        last_strobe = cyc;
        if (bus.cmd == 3'd0) begin ld_act = 1'b1; ld_c = cyc; end
      end
      if (ld_act) begin
        int rel;
        rel = cyc - ld_c;
        chk("load_img_rd", int'(bus.img_rd), int'(rel <= 107));
        if (rel <= 107) chk("load_img_addr", int'(bus.img_addr), rel);
        if (rel >= 1) begin
          chk("load_datain", int'(bus.datain), rel + 7);
          hold_exp = rel + 7;
        end else begin
          chk("datain_hold", int'(bus.datain), hold_exp);
        end
        if (rel == 108) ld_act = 1'b0;
      end else begin
        chk("img_rd_idle", int'(bus.img_rd), 0);
        chk("datain_hold", int'(bus.datain), hold_exp);
      end
    end
    cyc++;
  end

  // Stimulus: drive at posedge+1.
  task automatic push(input int c);
    bus.hcmd = 3'(c); bus.hcmd_push = 1'b1;
    @(posedge clk); #1;
    bus.hcmd_push = 1'b0;
  endtask
  task automatic expect_cmd(input int c, input int g);
    exp_t e; e.cmd = c; e.gap = g; exp_q.push_back(e);
  endtask
  task automatic stat(input int k, input int v);
    stat_t s; s.kind = k; s.val = v; stat_q.push_back(s);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // A bounded wait: an expired bound shows up as a failed seq_idle check.
  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (bus.seq_idle) break;
    end
    stat(1, 1);
    tick(1);
  endtask

  initial begin
    bus.hcmd = '0; bus.hcmd_push = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // One load, memory k -> k+8.
    expect_cmd(0, 0);
    push(0);
    wait_idle(300);

    // Three commands with busy held for 17 cycles after each strobe.
    busy_len = 17;
    expect_cmd(1, 0); expect_cmd(3, 19); expect_cmd(3, 19);
    push(1); push(3); push(3);
    wait_idle(200);

    // Fill with busy forced high. The 5th push is dropped.
    busy_len = 2;
    busy_force = 1'b1;
    push(1); push(2); push(3);
    stat(0, 0);
    tick(1);
    push(4);
    stat(0, 1);
    tick(1);
    push(5);
    stat(0, 1);
    stat(3, 1);
    tick(1);
    // Push while full, in the same cycle as the pop: the push is kept.
    expect_cmd(1, 0); expect_cmd(2, 0); expect_cmd(3, 0); expect_cmd(4, 0);
    expect_cmd(6, 0);
    bus.hcmd = 3'd6; bus.hcmd_push = 1'b1; busy_force = 1'b0;
    @(posedge clk); #1;
    bus.hcmd_push = 1'b0;
    stat(0, 1);
    tick(1);
    wait_idle(200);

    // Code 7 is discarded. Only cmd 2 is strobed.
    expect_cmd(2, 0);
    push(7); push(2);
    wait_idle(100);
    stat(3, 2);
    tick(1);

    // Reset around byte 50 of a load.
    expect_cmd(0, 0);
    push(0);
    tick(51);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(10);
    stat(1, 1); stat(0, 0); stat(3, 0); stat(2, 0);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
